// File: rtl/rs_pkg.sv
// rs_pkg: shared types and default sizes for the ALU reservation station.
// The struct field widths follow the *_D sizes below.
package rs_pkg;

  localparam int RS_DEPTH_D  = 8;
  localparam int NUM_CDB_D   = 4;
  localparam int NUM_ISSUE_D = 2;
  localparam int TAG_W_D     = 3;
  localparam int XLEN_D      = 32;
  localparam int OP_W_D      = 3;

  typedef enum logic [OP_W_D-1:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
    ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_e;

  typedef struct packed {
    logic                rdy;
    logic [TAG_W_D-1:0]  tag;
    logic [XLEN_D-1:0]   value;
  } rs_opnd_t;

  typedef struct packed {
    logic [OP_W_D-1:0]   op;
    logic [TAG_W_D-1:0]  rob_idx;
    rs_opnd_t            j;
    rs_opnd_t            k;
  } rs_entry_t;

  typedef struct packed {
    logic                valid;
    logic [TAG_W_D-1:0]  tag;
    logic [XLEN_D-1:0]   value;
  } cdb_lane_t;

endpackage

// File: rtl/age_select.sv
// age_select: picks the NUM_GRANT oldest ready entries.
// older[j][i] set means entry j is older than entry i.
module age_select #(
  parameter int DEPTH     = 8,
  parameter int NUM_GRANT = 2
) (
  input  logic [DEPTH-1:0]                ready,
  input  logic [DEPTH-1:0][DEPTH-1:0]     older,
  output logic [NUM_GRANT-1:0][DEPTH-1:0] grant
);

  // rank = number of ready entries older than i; rank k goes to port k
  always_comb begin
    int rank;
    grant = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rank = 0;
      for (int j = 0; j < DEPTH; j++)
        if (ready[j] && older[j][i])
          rank = rank + 1;
      for (int k = 0; k < NUM_GRANT; k++)
        if (ready[i] && rank == k)
          grant[k][i] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_rs_multi.sv
// alu_rs_multi: multi-issue ALU reservation station with CDB wakeup,
// dispatch bypass and age-ordered select.
module alu_rs_multi
  import rs_pkg::*;
#(
  parameter int RS_DEPTH  = RS_DEPTH_D,
  parameter int NUM_CDB   = NUM_CDB_D,
  parameter int NUM_ISSUE = NUM_ISSUE_D,
  parameter int TAG_W     = TAG_W_D,
  parameter int XLEN      = XLEN_D,
  parameter int OP_W      = OP_W_D
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         disp_valid,
  output logic                         disp_ready,
  input  logic [OP_W-1:0]              disp_op,
  input  logic [TAG_W-1:0]             disp_rob_idx,
  input  logic                         disp_j_rdy,
  input  logic                         disp_k_rdy,
  input  logic [XLEN-1:0]              disp_vj,
  input  logic [XLEN-1:0]              disp_vk,
  input  logic [TAG_W-1:0]             disp_qj,
  input  logic [TAG_W-1:0]             disp_qk,
  input  logic [NUM_CDB-1:0]           cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]     cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]      cdb_value,
  output logic [NUM_ISSUE-1:0]         iss_valid,
  input  logic [NUM_ISSUE-1:0]         iss_ready,
  output logic [NUM_ISSUE*OP_W-1:0]    iss_op,
  output logic [NUM_ISSUE*XLEN-1:0]    iss_vj,
  output logic [NUM_ISSUE*XLEN-1:0]    iss_vk,
  output logic [NUM_ISSUE*TAG_W-1:0]   iss_rob_idx,
  output logic [$clog2(RS_DEPTH+1)-1:0] free_count
);

  localparam int CW = $clog2(RS_DEPTH+1);

  logic [RS_DEPTH-1:0]                 busy, busy_nxt, surv;
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0]   older, older_nxt;
  logic [RS_DEPTH-1:0]                 rdy_vec, freed, disp_oh;
  logic [NUM_ISSUE-1:0][RS_DEPTH-1:0]  grant;
  logic                                disp_fire;
  cdb_lane_t [NUM_CDB-1:0]             lane;
  rs_entry_t                           ent   [RS_DEPTH];
  rs_entry_t                           woken [RS_DEPTH];
  rs_entry_t                           new_ent;
  rs_opnd_t                            dj, dk;

  // Lowest matching lane wins, so scan high to low.
  function automatic rs_opnd_t snoop(
    input rs_opnd_t                o,
    input cdb_lane_t [NUM_CDB-1:0] ln
  );
    rs_opnd_t r;
    r = o;
    for (int l = NUM_CDB - 1; l >= 0; l--)
      if (!o.rdy && ln[l].valid && ln[l].tag == o.tag) begin
        r.rdy   = 1'b1;
        r.value = ln[l].value;
      end
    return r;
  endfunction

  // Unpack CDB lanes
  always_comb begin
    for (int l = 0; l < NUM_CDB; l++) begin
      lane[l].valid = cdb_valid[l];
      lane[l].tag   = cdb_tag[l*TAG_W +: TAG_W];
      lane[l].value = cdb_value[l*XLEN +: XLEN];
    end
  end

  // Free count and dispatch readiness from registered state only
  always_comb begin
    free_count = CW'(RS_DEPTH);
    for (int i = 0; i < RS_DEPTH; i++)
      free_count = free_count - CW'(busy[i]);
    disp_ready = (free_count != '0);
    disp_fire  = disp_valid & disp_ready & ~flush;
  end

  // Lowest-index free slot, and the new entry with dispatch bypass
  always_comb begin
    disp_oh = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--)
      if (!busy[i]) begin
        disp_oh    = '0;
        disp_oh[i] = 1'b1;
      end
    dj.rdy   = disp_j_rdy;
    dj.tag   = disp_qj;
    dj.value = disp_vj;
    dk.rdy   = disp_k_rdy;
    dk.tag   = disp_qk;
    dk.value = disp_vk;
    new_ent.op      = disp_op;
    new_ent.rob_idx = disp_rob_idx;
    new_ent.j       = snoop(dj, lane);
    new_ent.k       = snoop(dk, lane);
  end

  // Wakeup of resident operands and the ready vector
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      woken[i]   = ent[i];
      woken[i].j = snoop(ent[i].j, lane);
      woken[i].k = snoop(ent[i].k, lane);
      rdy_vec[i] = busy[i] & ent[i].j.rdy & ent[i].k.rdy;
    end
  end

  age_select #(
    .DEPTH     (RS_DEPTH),
    .NUM_GRANT (NUM_ISSUE)
  ) u_sel (
    .ready (rdy_vec),
    .older (older),
    .grant (grant)
  );

  // Issue port muxing and handshake
  always_comb begin
    iss_valid   = '0;
    iss_op      = '0;
    iss_vj      = '0;
    iss_vk      = '0;
    iss_rob_idx = '0;
    freed       = '0;
    for (int k = 0; k < NUM_ISSUE; k++) begin
      iss_valid[k] = |grant[k];
      for (int i = 0; i < RS_DEPTH; i++)
        if (grant[k][i]) begin
          iss_op[k*OP_W +: OP_W]        = ent[i].op;
          iss_vj[k*XLEN +: XLEN]        = ent[i].j.value;
          iss_vk[k*XLEN +: XLEN]        = ent[i].k.value;
          iss_rob_idx[k*TAG_W +: TAG_W] = ent[i].rob_idx;
        end
      if (iss_valid[k] && iss_ready[k])
        freed = freed | grant[k];
    end
  end

  // Next busy set and age matrix; new entry is younger than all survivors
  always_comb begin
    surv      = busy & ~freed;
    busy_nxt  = surv;
    older_nxt = older;
    for (int i = 0; i < RS_DEPTH; i++)
      if (freed[i]) begin
        older_nxt[i] = '0;
        for (int j = 0; j < RS_DEPTH; j++)
          older_nxt[j][i] = 1'b0;
      end
    if (disp_fire) begin
      busy_nxt = surv | disp_oh;
      for (int i = 0; i < RS_DEPTH; i++)
        if (disp_oh[i]) begin
          older_nxt[i] = '0;
          for (int j = 0; j < RS_DEPTH; j++)
            older_nxt[j][i] = surv[j];
        end
    end
    if (flush) begin
      busy_nxt  = '0;
      older_nxt = '0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy  <= '0;
      older <= '0;
      for (int i = 0; i < RS_DEPTH; i++)
        ent[i] <= '0;
    end else begin
      busy  <= busy_nxt;
      older <= older_nxt;
      for (int i = 0; i < RS_DEPTH; i++)
        ent[i] <= (disp_fire && disp_oh[i]) ? new_ent : woken[i];
    end
  end

endmodule

// File: doc/alu_rs_multi.md
Name: alu_rs_multi

Overview:
Parametrised ALU reservation station, successor to the fixed 4-entry ALU RS.
- Holds up to RS_DEPTH decoded ALU ops; wakes operands from an N-wide CDB; issues up to NUM_ISSUE oldest-ready ops per cycle to ALUs over a valid/ready handshake.
- Sits between decoder/ROB dispatch and the ALU pool.
- New vs. predecessor: same-cycle CDB bypass at dispatch, age-ordered select, back-pressure from ALUs, free-entry count, async active-low reset.

Parameters:
- RS_DEPTH, 8, number of entries (≥2).
- NUM_CDB, 4, CDB broadcast lanes.
- NUM_ISSUE, 2, issue ports (1..RS_DEPTH).
- TAG_W, 3, ROB tag width.
- XLEN, 32, operand width.
- OP_W, 3, ALU op width (alu_ops).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  sync clear of all entries.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  at least one free entry.
- disp_op  in  OP_W  ALU op.
- disp_rob_idx  in  TAG_W  destination ROB tag.
- disp_j_rdy / disp_k_rdy  in  1 each  operand value already valid.
- disp_vj / disp_vk  in  XLEN each  operand values (used when rdy).
- disp_qj / disp_qk  in  TAG_W each  producer tags (used when !rdy).
- cdb_valid  in  NUM_CDB  lane valid.
- cdb_tag  in  NUM_CDB*TAG_W  lane tags.
- cdb_value  in  NUM_CDB*XLEN  lane values.
- iss_valid  out  NUM_ISSUE  port holds an op.
- iss_ready  in  NUM_ISSUE  ALU accepts.
- iss_op  out  NUM_ISSUE*OP_W  op per port.
- iss_vj / iss_vk  out  NUM_ISSUE*XLEN each  operands per port.
- iss_rob_idx  out  NUM_ISSUE*TAG_W  destination tag per port.
- free_count  out  $clog2(RS_DEPTH+1)  free entries.

Behaviour:
- Entry state: busy, op, rob_idx, {rdy, tag, value} for j and k.
- Reset (rst=0, async): all busy=0, age matrix cleared. Hence iss_valid=0, disp_ready=1, free_count=RS_DEPTH.
- Dispatch:
  - Fires when disp_valid & disp_ready.
  - Writes the lowest-index free entry at the clock edge.
  - disp_ready = (free_count != 0). Registered state only; a slot freed by a same-cycle issue is not counted.
  - disp_valid while !disp_ready is ignored.
- Bypass: a not-ready dispatched operand whose tag matches a valid CDB lane in the same cycle is captured as ready with that lane's value.
- Wakeup: every busy entry with a not-ready operand and a matching valid CDB lane captures the value at the edge.
  - On multiple lane matches, the lowest lane index wins.
  - Ready operands ignore the CDB.
- Ready entry = busy & j_rdy & k_rdy.
  - Earliest issue is the cycle after dispatch or after wakeup. There is no combinational CDB-to-issue path.
- Select (combinational from registered state):
  - Port k presents the k-th oldest ready entry; iss_valid[k]=0 if fewer than k+1 are ready.
  - Age comes from an RS_DEPTH×RS_DEPTH older-than matrix: set on dispatch, row and column cleared on free.
- Handshake:
  - Port k fires on iss_valid[k] & iss_ready[k]; that entry is freed at the edge.
  - A non-firing port's entry stays and is re-selected next cycle, possibly on a different port.
  - Outputs are stable only while state is unchanged, and the ALU must not rely on port stickiness.
- free_count(next) = free_count − dispatch_fire + number of issue fires.
  - Arithmetic is unsigned and never under- or overflows, given the rules above.
- Flush: all entries cleared at the edge. Flush beats same-cycle dispatch, which is dropped, and issue fires, which are dropped with no RS effect.
- rst asserted mid-operation: immediate clear regardless of clk; outputs reach reset values combinationally.

Decomposition:
- Package rs_pkg holds:
  - rs_entry_t (op, rob_idx, operand sub-struct rs_opnd_t {rdy, tag, value});
  - cdb lane struct;
  - default parameter constants.
- Sub-module age_select: input ready vector + age matrix; output NUM_ISSUE one-hot grants in age order. Purely combinational, unit-testable alone.

Test Plan:
- Async reset with 3 busy entries, rst=0 between edges → iss_valid=0 and free_count=8 immediately, disp_ready=1.
- Dispatch ADD, j_rdy=k_rdy=1, vj=5, vk=7, rob_idx=3 at cycle 0, iss_ready=1 → iss_valid[0]=1 at cycle 1 with vj=5, vk=7, rob_idx=3; free_count=8 at cycle 2.
- Dispatch with qj=2 not ready; CDB lane1 tag=2 value=0xDEAD at cycle 3 → issue at cycle 4 with vj=0xDEAD; no issue before cycle 4.
- Dispatch with qk=5 while CDB lane0 broadcasts tag=5 value=9 in the same cycle → issues next cycle with vk=9.
- Fill 8 ready entries with iss_ready=0 for 3 cycles → disp_ready=0 and extra dispatch ignored. Then iss_ready=2'b01 → port 0 issues 1st-dispatched, port 1 holds 2nd. Next cycle, port 0 shows the 2nd.
- 4 busy entries, flush=1 concurrent with disp_valid and iss_ready=all ones → next cycle free_count=8, iss_valid=0, dispatched op absent.
